// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder: packs decoded RV32I fields into 32-bit words and streams
// them into instruction memory through a registered 1-cycle write port.
module rv32i_instr_encoder #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_f7b5,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_IL   = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_U    = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;
    localparam logic [6:0] OP_J    = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_CLASS = 2'd1;
    localparam logic [1:0] ERR_IMM   = 2'd2;
    localparam logic [1:0] ERR_OVF   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic [1:0]          err_q, err_d;

    logic [31:0]         enc_c;
    logic                class_err_c;
    logic                imm_err_c;
    logic signed [31:0]  imm_s;
    logic                is_shift_c;
    logic [6:0]          f7_c;

    assign imm_s      = $signed(in_imm);
    assign is_shift_c = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
    assign f7_c       = {1'b0, in_f7b5, 5'b0};

    // Field packing and immediate range check for the presented bundle
    always_comb begin
        enc_c       = 32'd0;
        class_err_c = 1'b0;
        imm_err_c   = 1'b0;
        case (in_class)
            4'd0: enc_c = {f7_c, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            4'd1: begin
                if (is_shift_c) begin
                    enc_c     = {f7_c, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_I};
                    imm_err_c = (imm_s < 32'sd0) || (imm_s > 32'sd31);
                end else begin
                    enc_c     = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
                    imm_err_c = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
                end
            end
            4'd2: begin
                enc_c     = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IL};
                imm_err_c = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            end
            4'd3: begin
                enc_c     = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_S};
                imm_err_c = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            end
            4'd4: begin
                enc_c     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], OP_B};
                imm_err_c = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
            end
            4'd5: begin
                enc_c     = {in_imm[31:12], in_rd, OP_U};
                imm_err_c = (in_imm[11:0] != 12'd0);
            end
            4'd6: begin
                enc_c     = {in_imm[31:12], in_rd, OP_AUI};
                imm_err_c = (in_imm[11:0] != 12'd0);
            end
            4'd7: begin
                enc_c     = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_J};
                imm_err_c = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0];
            end
            4'd8: begin
                enc_c     = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_JALR};
                imm_err_c = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            end
            default: class_err_c = 1'b1;
        endcase
    end

    // Next-state: start/restart, accept-and-write, error capture
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        err_d   = err_q;
        if (start) begin
            state_d = ST_RUN;
            ptr_d   = ADDR_W'(BASE_ADDR);
            cnt_d   = '0;
            err_d   = ERR_NONE;
            done_d  = 1'b0;
        end else if ((state_q == ST_RUN) && in_valid) begin
            if (class_err_c) begin
                err_d   = ERR_CLASS;
                state_d = ST_ERROR;
            end else if (imm_err_c) begin
                err_d   = ERR_IMM;
                state_d = ST_ERROR;
            end else if (cnt_q == CNT_W'(DEPTH)) begin
                err_d   = ERR_OVF;
                state_d = ST_ERROR;
            end else begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = enc_c;
                ptr_d   = ptr_q + ADDR_W'(1);
                cnt_d   = cnt_q + CNT_W'(1);
                if (in_last) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
        end
        ready_d = (state_d == ST_RUN);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready   = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = done_q;
    assign err_code   = err_q;
    assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Scoreboard bench for rv32i_instr_encoder: stimulus pushes expected writes,
// a negedge monitor pops and compares every imem write.
module tb_rv32i_instr_encoder;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_class;
    logic [4:0]        in_rd, in_rs1, in_rs2;
    logic [2:0]        in_funct3;
    logic              in_f7b5;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              done;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   word_cnt;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [ADDR_W:0]   cnt;
        logic              done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    rv32i_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .done(done), .err_code(err_code), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Monitor: every write must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && imem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d wdata=0x%08h", imem_addr, imem_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (imem_addr !== e.addr || imem_wdata !== e.wdata ||
                    word_cnt !== e.cnt || done !== e.done) begin
                    errors++;
                    $display("FAIL write actual addr=%0d wdata=0x%08h cnt=%0d done=%0b required addr=%0d wdata=0x%08h cnt=%0d done=%0b",
                             imem_addr, imem_wdata, word_cnt, done, e.addr, e.wdata, e.cnt, e.done);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Present one bundle and hold it until accepted (bounded wait)
    task automatic send(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic f7b5,
                        input logic [31:0] imm, input logic last);
        int waited;
        in_class = cls; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_f7b5 = f7b5; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=ready_low required=ready_high");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    function automatic exp_t mk(input int a, input logic [31:0] w, input int c, input logic d);
        exp_t e;
        e.addr  = ADDR_W'(a);
        e.wdata = w;
        e.cnt   = (ADDR_W + 1)'(c);
        e.done  = d;
        return e;
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_class = '0; in_rd = '0;
        in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_f7b5 = 1'b0; in_imm = '0; in_last = 1'b0;
        idle(3);
        @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_err", 32'(err_code), 32'd0);
        chk("rst_cnt", 32'(word_cnt), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // addi x1,x0,5
        pulse_start();
        chk("start_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(mk(0, 32'h00500093, 1, 1'b0));
        send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0);
        idle(2);
        chk("addi_cnt", 32'(word_cnt), 32'd1);

        // sw x2,8(x1) (funct3=010) then beq x0,x0,-4 as last, back-to-back
        pulse_start();
        exp_q.push_back(mk(0, 32'h0020A423, 1, 1'b0));
        exp_q.push_back(mk(1, 32'hFE000EE3, 2, 1'b1));
        send(4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8, 1'b0);
        send(4'd4, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, -32'sd4, 1'b1);
        idle(2);
        chk("last_done", 32'(done), 32'd1);
        chk("last_ready", 32'(in_ready), 32'd0);

        // jal x1,2048 then misaligned jal
        pulse_start();
        chk("restart_done", 32'(done), 32'd0);
        exp_q.push_back(mk(0, 32'h001000EF, 1, 1'b0));
        send(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048, 1'b0);
        send(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3, 1'b0);
        idle(2);
        chk("jal_odd_err", 32'(err_code), 32'd2);
        chk("jal_odd_ready", 32'(in_ready), 32'd0);
        chk("jal_odd_cnt", 32'(word_cnt), 32'd1);

        // illegal class, then start clears
        pulse_start();
        send(4'd12, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 1'b0);
        idle(1);
        chk("class_err", 32'(err_code), 32'd1);
        pulse_start();
        chk("clr_err", 32'(err_code), 32'd0);
        chk("clr_cnt", 32'(word_cnt), 32'd0);
        chk("clr_ready", 32'(in_ready), 32'd1);

        // shift amount 32 is out of range
        send(4'd1, 5'd3, 5'd1, 5'd0, 3'd1, 1'b0, 32'd32, 1'b0);
        idle(1);
        chk("shamt_err", 32'(err_code), 32'd2);

        // overflow at DEPTH=4: addi, srai x3,x1,31, sub x5,x6,x7, lui x10, then a dropped 5th
        pulse_start();
        exp_q.push_back(mk(0, 32'h00700113, 1, 1'b0));
        exp_q.push_back(mk(1, 32'h41F0D193, 2, 1'b0));
        exp_q.push_back(mk(2, 32'h407302B3, 3, 1'b0));
        exp_q.push_back(mk(3, 32'h12345537, 4, 1'b0));
        send(4'd1, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd7, 1'b0);
        send(4'd1, 5'd3, 5'd1, 5'd0, 3'd5, 1'b1, 32'd31, 1'b0);
        send(4'd0, 5'd5, 5'd6, 5'd7, 3'd0, 1'b1, 32'd0, 1'b0);
        send(4'd5, 5'd10, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, 1'b0);
        send(4'd1, 5'd4, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1, 1'b0);
        idle(2);
        chk("ovf_err", 32'(err_code), 32'd3);
        chk("ovf_cnt", 32'(word_cnt), 32'd4);

        // reset coinciding with an accept drops the word
        pulse_start();
        in_class = 4'd1; in_rd = 5'd1; in_rs1 = 5'd0; in_funct3 = 3'd0; in_imm = 32'd9;
        in_last = 1'b0; in_valid = 1'b1; rst_n = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_we", 32'(imem_we), 32'd0);
        chk("rst_mid_ready", 32'(in_ready), 32'd0);
        chk("rst_mid_cnt", 32'(word_cnt), 32'd0);
        chk("rst_mid_wdata", imem_wdata, 32'd0);
        chk("rst_mid_err", 32'(err_code), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
